// File: rtl/pim_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pim_mem_arbiter_pkg
// Brief    : Shared constants and request type for the PIM memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package pim_mem_arbiter_pkg;

    localparam int NUM_OF_PIM_UNITS = 4;
    localparam int WIDTH            = 32;
    localparam int LEN              = 10;
    localparam int PIM_ID_W         = $clog2(NUM_OF_PIM_UNITS);
    localparam int MEM_RD_LAT       = 2;

    typedef struct packed {
        logic             we;
        logic [LEN-1:0]   addr;
        logic [WIDTH-1:0] wdata;
    } pim_mem_req_t;

endpackage
`default_nettype wire

// File: rtl/pim_mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin picker; search starts after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx
);

    logic [ID_W-1:0] w_cand;
    logic            w_found;

    // N is a power of two, so ptr+k wraps modulo N for free; k=N revisits ptr last.
    always_comb begin
        grant   = '0;
        idx     = ptr;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_cand = ptr + k[ID_W-1:0];
            if (!w_found && req[w_cand]) begin
                w_found       = 1'b1;
                grant[w_cand] = 1'b1;
                idx           = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pim_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pim_mem_arbiter
// Brief    : Round-robin arbiter sharing one single-port memory among PIM
//            units; optional grant counters under PIM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pim_mem_arbiter
    import pim_mem_arbiter_pkg::*;
#(
    parameter int N      = NUM_OF_PIM_UNITS,
    parameter int DATA_W = WIDTH,
    parameter int ADDR_W = LEN,
    parameter int RD_LAT = MEM_RD_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req_valid,
    input  logic [N-1:0]        req_we,
    input  logic [N*ADDR_W-1:0] req_addr,
    input  logic [N*DATA_W-1:0] req_wdata,
    output logic [N-1:0]        req_ready,
    output logic [N-1:0]        rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
`ifdef PIM_ARB_STATS_EN
    input  logic                stats_clr,
    output logic [N*16-1:0]     grant_cnt,
`endif
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int ID_W = $clog2(N);

    logic [N-1:0]      w_grant;
    logic [ID_W-1:0]   w_win_idx;
    logic              w_hs;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [RD_LAT:0]   tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]   tag_id_q [RD_LAT+1];
    logic [ID_W-1:0]   tag_id_d [RD_LAT+1];

    rr_picker #(
        .N    (N),
        .ID_W (ID_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (w_grant),
        .idx   (w_win_idx)
    );

    assign w_hs        = |w_grant;
    assign w_win_we    = req_we[w_win_idx];
    assign w_win_addr  = req_addr[w_win_idx*ADDR_W +: ADDR_W];
    assign w_win_wdata = req_wdata[w_win_idx*DATA_W +: DATA_W];

    always_comb begin
        ptr_d       = ptr_q;
        mem_en_d    = w_hs;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (w_hs) begin
            ptr_d       = w_win_idx;
            mem_we_d    = w_win_we;
            mem_addr_d  = w_win_addr;
            mem_wdata_d = w_win_wdata;
        end
        // Tag stage k is valid in cycle t+1+k for a read granted in cycle t.
        tag_vld_d   = {tag_vld_q[RD_LAT-1:0], w_hs & ~w_win_we};
        tag_id_d[0] = w_win_idx;
        for (int k = 1; k <= RD_LAT; k++) begin
            tag_id_d[k] = tag_id_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= ID_W'(N-1);
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_vld_q   <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag_vld_q   <= tag_vld_d;
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (tag_vld_q[RD_LAT]) begin
            rsp_valid[tag_id_q[RD_LAT]] = 1'b1;
        end
    end

    assign req_ready = w_grant;
    assign rsp_rdata = mem_rdata;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef PIM_ARB_STATS_EN
    logic [15:0] cnt_q [N];
    logic [15:0] cnt_d [N];

    // Clear has priority over a same-cycle grant; counters stick at all-ones.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stats_clr) begin
                cnt_d[i] = '0;
            end else if (w_grant[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_grant_cnt
        assign grant_cnt[gi*16 +: 16] = cnt_q[gi];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pim_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pim_mem_arbiter
// Brief    : Directed self-checking bench for pim_mem_arbiter with a
//            two-cycle-latency memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pim_mem_arbiter;

    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    logic                clk;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_we;
    logic [N*ADDR_W-1:0] req_addr;
    logic [N*DATA_W-1:0] req_wdata;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
`ifdef PIM_ARB_STATS_EN
    logic                stats_clr;
    logic [N*16-1:0]     grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pim_mem_arbiter #(
        .N      (N),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef PIM_ARB_STATS_EN
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt),
`endif
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: write-before-read, read data two cycles after mem_en.
    logic [DATA_W-1:0] mem [1024];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hCAFE0000 + i;
        rd1 = '0;
        rd2 = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        rd1 <= mem[mem_addr];
        end
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int u, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_we[u]                   = we;
        req_addr[u*ADDR_W +: ADDR_W] = a;
        req_wdata[u*DATA_W +: DATA_W] = d;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef PIM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        tick();
        tick();
        chk("rst_ready",  {60'd0, req_ready}, 64'd0);
        chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_addr",   {54'd0, mem_addr}, 64'd0);
        chk("rst_wdata",  {32'd0, mem_wdata}, 64'd0);
        chk("rst_rsp",    {60'd0, rsp_valid}, 64'd0);
        rst_n = 1'b1;

        // Single read by unit 2.
        set_req(2, 1'b0, 10'h005, 32'h0);
        req_valid = 4'b0100;
        settle();
        chk("rd2_ready", {60'd0, req_ready}, 64'h4);
        tick();
        req_valid = '0;
        settle();
        chk("rd2_mem_en",   {63'd0, mem_en}, 64'd1);
        chk("rd2_mem_we",   {63'd0, mem_we}, 64'd0);
        chk("rd2_mem_addr", {54'd0, mem_addr}, 64'h5);
        chk("rd2_rsp_t1",   {60'd0, rsp_valid}, 64'd0);
        tick();
        chk("rd2_mem_en_t2", {63'd0, mem_en}, 64'd0);
        chk("rd2_rsp_t2",    {60'd0, rsp_valid}, 64'd0);
        tick();
        chk("rd2_rsp_valid", {60'd0, rsp_valid}, 64'h4);
        chk("rd2_rsp_data",  {32'd0, rsp_rdata}, 64'hCAFE0005);

        // All four request continuously from a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int u = 0; u < N; u++) set_req(u, 1'b0, 10'h010 + 10'(u), 32'h0);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("rr_ready", {60'd0, req_ready}, 64'(1 << (k % 4)));
            if (k >= 1) begin
                chk("rr_mem_en",   {63'd0, mem_en}, 64'd1);
                chk("rr_mem_addr", {54'd0, mem_addr}, 64'(10'h010 + (k - 1) % 4));
            end
            if (k >= 3) begin
                chk("rr_rsp_valid", {60'd0, rsp_valid}, 64'(1 << ((k - 3) % 4)));
                chk("rr_rsp_data",  {32'd0, rsp_rdata}, 64'(32'hCAFE0010 + (k - 3) % 4));
            end
            tick();
        end

        // Unit 1 alone; then units 3,0,1 contend with the search starting at 2.
        req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("solo1_ready", {60'd0, req_ready}, 64'h2);
            tick();
        end
        req_valid = 4'b1011;
        settle();
        chk("ctd_first3", {60'd0, req_ready}, 64'h8);
        tick();
        req_valid = 4'b0011;
        settle();
        chk("ctd_then0", {60'd0, req_ready}, 64'h1);
        tick();
        req_valid = 4'b0010;
        settle();
        chk("ctd_then1", {60'd0, req_ready}, 64'h2);
        tick();
        req_valid = '0;
        tick();
        tick();
        tick();

        // Write by unit 0 then back-to-back read of the same word by unit 3.
        set_req(0, 1'b1, 10'h3FF, 32'h12345678);
        set_req(3, 1'b0, 10'h3FF, 32'h0);
        req_valid = 4'b0001;
        settle();
        chk("wr_ready", {60'd0, req_ready}, 64'h1);
        tick();
        req_valid = 4'b1000;
        settle();
        chk("rd3_ready",    {60'd0, req_ready}, 64'h8);
        chk("wr_mem_en",    {63'd0, mem_en}, 64'd1);
        chk("wr_mem_we",    {63'd0, mem_we}, 64'd1);
        chk("wr_mem_addr",  {54'd0, mem_addr}, 64'h3FF);
        chk("wr_mem_wdata", {32'd0, mem_wdata}, 64'h12345678);
        tick();
        req_valid = '0;
        set_req(0, 1'b0, 10'h000, 32'h0);
        settle();
        chk("rd3_mem_en",   {63'd0, mem_en}, 64'd1);
        chk("rd3_mem_we",   {63'd0, mem_we}, 64'd0);
        chk("rd3_mem_addr", {54'd0, mem_addr}, 64'h3FF);
        chk("wr_no_rsp",    {60'd0, rsp_valid}, 64'd0);
        tick();
        chk("wr_no_rsp_t3", {60'd0, rsp_valid}, 64'd0);
        tick();
        chk("rd3_rsp_valid", {60'd0, rsp_valid}, 64'h8);
        chk("rd3_rsp_data",  {32'd0, rsp_rdata}, 64'h12345678);
        tick();

        // Three reads in flight, then a one-cycle reset pulse drops them.
        for (int u = 0; u < 3; u++) set_req(u, 1'b0, 10'h020 + 10'(u), 32'h0);
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("fl_ready", {60'd0, req_ready}, 64'(1 << k));
            tick();
        end
        req_valid = '0;
        rst_n     = 1'b0;
        settle();
        chk("mid_rst_ready", {60'd0, req_ready}, 64'd0);
        chk("mid_rst_en",    {63'd0, mem_en}, 64'd0);
        chk("mid_rst_we",    {63'd0, mem_we}, 64'd0);
        chk("mid_rst_addr",  {54'd0, mem_addr}, 64'd0);
        chk("mid_rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("mid_rst_rsp",   {60'd0, rsp_valid}, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("post_rst_no_rsp", {60'd0, rsp_valid}, 64'd0);
            tick();
        end
        req_valid = 4'b1111;
        settle();
        chk("post_rst_first", {60'd0, req_ready}, 64'h1);
        tick();
        req_valid = '0;

`ifdef PIM_ARB_STATS_EN
        set_req(2, 1'b0, 10'h030, 32'h0);
        req_valid = 4'b0100;
        for (int k = 0; k < 10; k++) tick();
        req_valid = '0;
        settle();
        chk("cnt2_ten",  {48'd0, grant_cnt[32 +: 16]}, 64'd10);
        chk("cnt0_one",  {48'd0, grant_cnt[0 +: 16]}, 64'd1);
        req_valid = 4'b0100;
        stats_clr = 1'b1;
        tick();
        req_valid = '0;
        stats_clr = 1'b0;
        settle();
        chk("cnt2_clr",  {48'd0, grant_cnt[32 +: 16]}, 64'd0);
        chk("cnt0_clr",  {48'd0, grant_cnt[0 +: 16]}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
